// File: rtl/reservation_station.sv
// Age-ordered reservation station: captures renamed operands, wakes them on completion broadcast, issues oldest ready entry.
// Optional RS_WAKEUP_BYPASS_EN lets a broadcast make an entry issuable in the same cycle.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int OP_W  = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flash,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic                       in_src1_valid,
  input  logic                       in_src2_valid,
  input  logic [31:0]                in_src1,
  input  logic [31:0]                in_src2,
  input  logic [15:0]                in_dest_phys,
  input  logic [7:0]                 in_dest_logic,
  input  logic                       wb_en,
  input  logic [15:0]                wb_tag,
  input  logic [31:0]                wb_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OP_W-1:0]            out_op,
  output logic [31:0]                out_src1,
  output logic [31:0]                out_src2,
  output logic [15:0]                out_dest_phys,
  output logic [7:0]                 out_dest_logic,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

`ifdef RS_WAKEUP_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            s1v;
    logic [31:0]     s1;
    logic            s2v;
    logic [31:0]     s2;
    logic [15:0]     dphys;
    logic [7:0]      dlogic;
  } entry_t;

  entry_t          slots [DEPTH];
  entry_t          woke  [DEPTH];
  entry_t          nxt   [DEPTH];
  entry_t          incoming;
  entry_t          sel_e;
  logic [DEPTH-1:0] hit1, hit2, rdy;
  logic [IW-1:0]   sel;
  logic            any_rdy, issue, accept;
  logic [CW-1:0]   wr_idx, count_nxt;

  assign in_ready = count < CW'(DEPTH);

  // Operand tag match against the current broadcast and per-slot readiness.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    rdy  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit1[i] = wb_en && !slots[i].s1v && (slots[i].s1[15:0] == wb_tag);
      hit2[i] = wb_en && !slots[i].s2v && (slots[i].s2[15:0] == wb_tag);
      rdy[i]  = (CW'(i) < count)
                && (slots[i].s1v || (BYPASS && hit1[i]))
                && (slots[i].s2v || (BYPASS && hit2[i]));
    end
  end

  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!any_rdy && rdy[i]) begin
        any_rdy = 1'b1;
        sel     = IW'(i);
      end
    end
  end

  assign sel_e = slots[sel];

  // An operand still pending on a ready slot can only be the bypassed broadcast.
  always_comb begin
    out_valid      = any_rdy;
    out_op         = '0;
    out_src1       = '0;
    out_src2       = '0;
    out_dest_phys  = '0;
    out_dest_logic = '0;
    if (any_rdy) begin
      out_op         = sel_e.op;
      out_src1       = sel_e.s1v ? sel_e.s1 : wb_data;
      out_src2       = sel_e.s2v ? sel_e.s2 : wb_data;
      out_dest_phys  = sel_e.dphys;
      out_dest_logic = sel_e.dlogic;
    end
  end

  assign issue  = any_rdy && out_ready && !flash;
  assign accept = in_valid && in_ready && !flash;
  assign wr_idx = count - CW'(issue);

  always_comb begin
    incoming.op     = in_op;
    incoming.dphys  = in_dest_phys;
    incoming.dlogic = in_dest_logic;
    incoming.s1v    = in_src1_valid || (wb_en && (in_src1[15:0] == wb_tag));
    incoming.s1     = (!in_src1_valid && wb_en && (in_src1[15:0] == wb_tag)) ? wb_data : in_src1;
    incoming.s2v    = in_src2_valid || (wb_en && (in_src2[15:0] == wb_tag));
    incoming.s2     = (!in_src2_valid && wb_en && (in_src2[15:0] == wb_tag)) ? wb_data : in_src2;
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = slots[i];
      if (hit1[i]) begin
        woke[i].s1v = 1'b1;
        woke[i].s1  = wb_data;
      end
      if (hit2[i]) begin
        woke[i].s2v = 1'b1;
        woke[i].s2  = wb_data;
      end
    end
  end

  // Compaction shifts younger slots down over the issued one; the new entry lands after the shift.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      nxt[i] = woke[i];
      if (issue && (IW'(i) >= sel) && (i < DEPTH - 1))
        nxt[i] = woke[i+1];
      if (accept && (CW'(i) == wr_idx))
        nxt[i] = incoming;
    end
  end

  always_comb begin
    count_nxt = count + CW'(accept) - CW'(issue);
    if (flash)
      count_nxt = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        slots[i] <= '0;
    end else begin
      count <= count_nxt;
      for (int unsigned i = 0; i < DEPTH; i++)
        slots[i] <= nxt[i];
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Randomized and directed bench for reservation_station against a queue-based reference model.
module tb_reservation_station;

  localparam int DEPTH = 4;
  localparam int OP_W  = 8;
  localparam int CW    = $clog2(DEPTH + 1);

`ifdef RS_WAKEUP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clock, reset_n, flash, in_valid, in_ready;
  logic [OP_W-1:0] in_op, out_op;
  logic            in_src1_valid, in_src2_valid;
  logic [31:0]     in_src1, in_src2, wb_data, out_src1, out_src2;
  logic [15:0]     in_dest_phys, wb_tag, out_dest_phys;
  logic [7:0]      in_dest_logic, out_dest_logic;
  logic            wb_en, out_valid, out_ready;
  logic [CW-1:0]   count;

  reservation_station #(.DEPTH(DEPTH), .OP_W(OP_W)) dut (
    .clock(clock), .reset_n(reset_n), .flash(flash),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1_valid(in_src1_valid), .in_src2_valid(in_src2_valid),
    .in_src1(in_src1), .in_src2(in_src2),
    .in_dest_phys(in_dest_phys), .in_dest_logic(in_dest_logic),
    .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_src1(out_src1), .out_src2(out_src2),
    .out_dest_phys(out_dest_phys), .out_dest_logic(out_dest_logic),
    .count(count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  op;
    bit          v1;
    logic [31:0] s1;
    bit          v2;
    logic [31:0] s2;
    logic [15:0] dp;
    logic [7:0]  dl;
  } ent_t;

  typedef logic [2+CW+96-1:0] vec_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic bit opnd_ok(bit v, logic [31:0] s);
    return v || (BYP && wb_en === 1'b1 && s[15:0] == wb_tag);
  endfunction

  function automatic int model_sel();
    foreach (q[i])
      if (opnd_ok(q[i].v1, q[i].s1) && opnd_ok(q[i].v2, q[i].s2))
        return i;
    return -1;
  endfunction

  function automatic vec_t model_vec();
    int s = model_sel();
    logic rdy_exp = (q.size() < DEPTH);
    logic [CW-1:0] c = CW'(q.size());
    ent_t e;
    if (s < 0)
      return {1'b0, rdy_exp, c, 96'b0};
    e = q[s];
    return {1'b1, rdy_exp, c, e.op, (e.v1 ? e.s1 : wb_data), (e.v2 ? e.s2 : wb_data), e.dp, e.dl};
  endfunction

  function automatic vec_t dut_vec();
    return {out_valid, in_ready, count,
            (out_valid === 1'b1) ? {out_op, out_src1, out_src2, out_dest_phys, out_dest_logic} : 96'b0};
  endfunction

  // Reference model: apply this cycle's flush / broadcast / issue / dispatch, then advance one edge.
  task automatic model_tick();
    int   s   = model_sel();
    bit   iss = (s >= 0) && out_ready && !flash;
    bit   acc = in_valid && (q.size() < DEPTH) && !flash;
    ent_t n;
    n.op = in_op; n.dp = in_dest_phys; n.dl = in_dest_logic;
    n.v1 = in_src1_valid; n.s1 = in_src1;
    n.v2 = in_src2_valid; n.s2 = in_src2;
    if (wb_en && !n.v1 && n.s1[15:0] == wb_tag) begin n.v1 = 1; n.s1 = wb_data; end
    if (wb_en && !n.v2 && n.s2[15:0] == wb_tag) begin n.v2 = 1; n.s2 = wb_data; end
    if (flash) q.delete();
    else begin
      foreach (q[i]) begin
        if (wb_en && !q[i].v1 && q[i].s1[15:0] == wb_tag) begin q[i].v1 = 1; q[i].s1 = wb_data; end
        if (wb_en && !q[i].v2 && q[i].s2[15:0] == wb_tag) begin q[i].v2 = 1; q[i].s2 = wb_data; end
      end
      if (iss) q.delete(s);
      if (acc) q.push_back(n);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_op = '0; in_src1_valid = 0; in_src2_valid = 0;
    in_src1 = '0; in_src2 = '0; in_dest_phys = '0; in_dest_logic = '0;
    wb_en = 0; wb_tag = '0; wb_data = '0; out_ready = 0; flash = 0;
  endtask

  task automatic dispatch(bit v, logic [7:0] op, bit v1, logic [31:0] s1, bit v2, logic [31:0] s2,
                          logic [15:0] dp, logic [7:0] dl);
    in_valid = v; in_op = op; in_src1_valid = v1; in_src1 = s1;
    in_src2_valid = v2; in_src2 = s2; in_dest_phys = dp; in_dest_logic = dl;
  endtask

  task automatic broadcast(bit en, logic [15:0] tag, logic [31:0] data);
    wb_en = en; wb_tag = tag; wb_data = data;
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    q.delete();
    @(posedge clock);
    #1;
    n_checks++;
    if ({out_valid, in_ready, count, out_op, out_src1, out_src2, out_dest_phys, out_dest_logic}
        !== {1'b0, 1'b1, CW'(0), 96'b0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b rdy=%b cnt=%0d src1=%h, want v=0 rdy=1 cnt=0 data=0",
               out_valid, in_ready, count, out_src1);
    end
    reset_n = 1;
  endtask

  task automatic test_basic();
    test_reset();
    dispatch(1, 8'h11, 1, 32'd5, 1, 32'd7, 16'd3, 8'd1);
    @(negedge clock);
    n_checks++;
    if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL basic_disp: got %h want %h", dut_vec(), model_vec()); end
    model_tick();
    idle();
    @(negedge clock);
    n_checks++;
    if ({out_valid, out_op, out_src1, out_src2, out_dest_phys} !== {1'b1, 8'h11, 32'd5, 32'd7, 16'd3}) begin
      n_fail++;
      $display("FAIL basic_out: got v=%b op=%h s1=%0d s2=%0d dp=%0d want 1 11 5 7 3",
               out_valid, out_op, out_src1, out_src2, out_dest_phys);
    end
    model_tick();
    out_ready = 1;
    @(negedge clock);
    model_tick();
    out_ready = 0;
    @(negedge clock);
    n_checks++;
    if ({count, out_valid} !== {CW'(0), 1'b0}) begin
      n_fail++; $display("FAIL basic_free: got cnt=%0d v=%b want cnt=0 v=0", count, out_valid);
    end
  endtask

  task automatic test_wakeup();
    test_reset();
    dispatch(1, 8'hA1, 0, 32'h20, 1, 32'd2, 16'h50, 8'd5);
    @(negedge clock); model_tick();
    dispatch(1, 8'hB2, 1, 32'h11, 1, 32'h22, 16'h51, 8'd6);
    @(negedge clock); model_tick();
    idle(); out_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({out_valid, out_dest_phys} !== {1'b1, 16'h51}) begin
      n_fail++; $display("FAIL wake_young_first: got v=%b dp=%h want v=1 dp=51", out_valid, out_dest_phys);
    end
    model_tick();
    broadcast(1, 16'h20, 32'hDEAD);
    @(negedge clock);
    n_checks++;
    if ({out_valid, (out_valid === 1'b1) ? out_src1 : 32'h0} !== {BYP, BYP ? 32'hDEAD : 32'h0}) begin
      n_fail++; $display("FAIL wake_bcast_cycle: got v=%b s1=%h want v=%b", out_valid, out_src1, BYP);
    end
    model_tick();
    broadcast(0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL wake_after[%0d]: got %h want %h", k, dut_vec(), model_vec()); end
      model_tick();
    end
  endtask

  task automatic test_capture();
    test_reset();
    dispatch(1, 8'hC3, 0, 32'hFFFF0030, 1, 32'd4, 16'h60, 8'd7);
    broadcast(1, 16'h30, 32'd9);
    out_ready = 1;
    @(negedge clock);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL capture_nobypass: got v=%b want v=0", out_valid); end
    model_tick();
    idle(); out_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({out_valid, out_src1, out_src2} !== {1'b1, 32'd9, 32'd4}) begin
      n_fail++; $display("FAIL capture_issue: got v=%b s1=%h s2=%h want 1 9 4", out_valid, out_src1, out_src2);
    end
    model_tick();
  endtask

  task automatic test_full();
    test_reset();
    for (int k = 0; k < 5; k++) begin
      dispatch(1, 8'(8'h40 + k), 0, 32'(32'h40 + k), 1, 32'd7, 16'(16'h70 + k), 8'(k));
      @(negedge clock);
      n_checks++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL full_fill[%0d]: got %h want %h", k, dut_vec(), model_vec()); end
      if (k == 4) begin
        n_checks++;
        if ({in_ready, count} !== {1'b0, CW'(4)}) begin
          n_fail++; $display("FAIL full_block: got rdy=%b cnt=%0d want rdy=0 cnt=4", in_ready, count);
        end
      end
      model_tick();
    end
    broadcast(1, 16'h40, 32'h1234);
    out_ready = 1;
    @(negedge clock);
    n_checks++;
    if ({in_ready, count, out_valid} !== {1'b0, CW'(4), BYP}) begin
      n_fail++; $display("FAIL full_issue_noacc: got rdy=%b cnt=%0d v=%b want 0 4 %b", in_ready, count, out_valid, BYP);
    end
    model_tick();
    broadcast(0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL full_after[%0d]: got %h want %h", k, dut_vec(), model_vec()); end
      model_tick();
    end
  endtask

  task automatic test_stall();
    logic [15:0] order [3];
    test_reset();
    for (int k = 0; k < 3; k++) begin
      dispatch(1, 8'(8'h80 + k), 1, 32'(100 + k), 1, 32'(200 + k), 16'(16'h90 + k), 8'(k));
      @(negedge clock); model_tick();
    end
    idle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++;
      if ({out_valid, out_dest_phys, out_src1, count} !== {1'b1, 16'h90, 32'd100, CW'(3)}) begin
        n_fail++; $display("FAIL stall[%0d]: got v=%b dp=%h s1=%0d cnt=%0d want 1 90 100 3",
                           k, out_valid, out_dest_phys, out_src1, count);
      end
      model_tick();
    end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      order[k] = out_dest_phys;
      n_checks++;
      if ({out_valid, out_dest_phys} !== {1'b1, 16'(16'h90 + k)}) begin
        n_fail++; $display("FAIL drain_order[%0d]: got v=%b dp=%h want v=1 dp=%h", k, out_valid, out_dest_phys, 16'h90 + k);
      end
      model_tick();
    end
    n_checks++;
    if (count !== CW'(0)) begin n_fail++; $display("FAIL drain_empty: got cnt=%0d want 0", count); end
  endtask

  task automatic test_flash();
    test_reset();
    for (int k = 0; k < 3; k++) begin
      dispatch(1, 8'(k), 1, 32'(k), (k != 1), 32'h55, 16'(16'hA0 + k), 8'(k));
      @(negedge clock); model_tick();
    end
    dispatch(1, 8'hEE, 1, 32'd1, 1, 32'd2, 16'hAF, 8'd9);
    broadcast(1, 16'h55, 32'h77);
    out_ready = 1; flash = 1;
    @(negedge clock);
    n_checks++;
    if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL flash_cycle: got %h want %h", dut_vec(), model_vec()); end
    model_tick();
    idle();
    @(negedge clock);
    n_checks++;
    if ({count, out_valid, in_ready} !== {CW'(0), 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flash_after: got cnt=%0d v=%b rdy=%b want 0 0 1", count, out_valid, in_ready);
    end
    model_tick();
  endtask

  task automatic test_async_reset();
    test_reset();
    for (int k = 0; k < 2; k++) begin
      dispatch(1, 8'h33, 1, 32'd3, 1, 32'd4, 16'(16'hB0 + k), 8'd2);
      @(negedge clock); model_tick();
    end
    idle();
    #2;
    reset_n = 0;
    q.delete();
    #1;
    n_checks++;
    if ({out_valid, in_ready, count, out_src1, out_dest_phys} !== {1'b0, 1'b1, CW'(0), 32'h0, 16'h0}) begin
      n_fail++; $display("FAIL async_reset: got v=%b rdy=%b cnt=%0d want 0 1 0", out_valid, in_ready, count);
    end
    #3;
    reset_n = 1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    logic [15:0] tag;
    test_reset();
    for (int c = 0; c < 800; c++) begin
      tag = 16'(16'h100 + $urandom_range(0, 5));
      in_valid      = ($urandom_range(0, 2) != 0);
      in_op         = 8'($urandom);
      in_src1_valid = ($urandom_range(0, 2) == 0);
      in_src1       = in_src1_valid ? $urandom : {16'($urandom), tag};
      tag = 16'(16'h100 + $urandom_range(0, 5));
      in_src2_valid = ($urandom_range(0, 2) == 0);
      in_src2       = in_src2_valid ? $urandom : {16'($urandom), tag};
      in_dest_phys  = 16'($urandom);
      in_dest_logic = 8'($urandom);
      wb_en         = ($urandom_range(0, 1) == 1);
      wb_tag        = 16'(16'h100 + $urandom_range(0, 5));
      wb_data       = $urandom;
      out_ready     = ($urandom_range(0, 3) != 0);
      flash         = ($urandom_range(0, 59) == 0);
      @(negedge clock);
      n_checks++;
      if (dut_vec() !== model_vec()) begin n_fail++; $display("FAIL random[%0d]: got %h want %h", c, dut_vec(), model_vec()); end
      model_tick();
    end
    idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset_n = 1;
    #1;
    test_reset();
    test_basic();
    test_wakeup();
    test_capture();
    test_full();
    test_stall();
    test_flash();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
